debug_ring_chain: RTL and testbench

//  Parametrised debug-ring interconnect for N-tile systems. Links the host debug interface and NODES tiles into a CHANNELS-wide ring.

---
 rtl/debug_ring_chain.sv | 152 +++++++++++++++
 tb/tb_debug_ring_chain.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_ring_chain.sv
// Debug-ring interconnect: host -> t0 -> .. -> t(N-1) -> host, with a per-hop, per-channel FIFO.
// Optional per-hop flit/stall counters are built when DEBUG_RING_STATS_EN is defined.
module debug_ring_fifo #(
    parameter int FLIT_WIDTH = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    input  logic                  i_last,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [FLIT_WIDTH-1:0] o_flit,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  i_ready
);
    if (BUF_DEPTH == 0) begin : g_wire
        assign o_flit  = i_flit;
        assign o_last  = i_last;
        assign o_valid = i_valid;
        assign o_ready = i_ready;
    end else begin : g_fifo
        localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
        localparam int CW = $clog2(BUF_DEPTH + 1);

        logic [FLIT_WIDTH:0] r_mem [BUF_DEPTH];
        logic [PW-1:0]       r_wptr, r_rptr;
        logic [CW-1:0]       r_count;
        logic                w_full, w_push, w_pop;

        // A full FIFO refuses a push even when a pop frees a slot this cycle.
        assign w_full  = (r_count == CW'(BUF_DEPTH));
        assign w_push  = i_valid && !w_full && !rst;
        assign w_pop   = (r_count != '0) && i_ready && !rst;
        assign o_ready = !w_full && !rst;
        assign o_valid = (r_count != '0) && !rst;
        assign {o_last, o_flit} = rst ? '0 : r_mem[r_rptr];

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= {i_last, i_flit};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= (r_wptr == PW'(BUF_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
                if (w_pop)  r_rptr <= (r_rptr == PW'(BUF_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule

module debug_ring_chain #(
    parameter int NODES      = 1,
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS*FLIT_WIDTH-1:0]       host_out_flit,
    input  logic [CHANNELS-1:0]                  host_out_last,
    input  logic [CHANNELS-1:0]                  host_out_valid,
    output logic [CHANNELS-1:0]                  host_out_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0]       host_in_flit,
    output logic [CHANNELS-1:0]                  host_in_last,
    output logic [CHANNELS-1:0]                  host_in_valid,
    input  logic [CHANNELS-1:0]                  host_in_ready,
    input  logic [NODES*CHANNELS*FLIT_WIDTH-1:0] tile_out_flit,
    input  logic [NODES*CHANNELS-1:0]            tile_out_last,
    input  logic [NODES*CHANNELS-1:0]            tile_out_valid,
    output logic [NODES*CHANNELS-1:0]            tile_out_ready,
    output logic [NODES*CHANNELS*FLIT_WIDTH-1:0] tile_in_flit,
    output logic [NODES*CHANNELS-1:0]            tile_in_last,
    output logic [NODES*CHANNELS-1:0]            tile_in_valid,
    input  logic [NODES*CHANNELS-1:0]            tile_in_ready,
    output logic [(NODES+1)*CHANNELS*32-1:0]     stat_flits,
    output logic [(NODES+1)*CHANNELS*32-1:0]     stat_stalls
);
    logic [NODES:0][CHANNELS-1:0][FLIT_WIDTH-1:0] w_src_flit, w_snk_flit;
    logic [NODES:0][CHANNELS-1:0] w_src_last, w_src_vld, w_src_rdy;
    logic [NODES:0][CHANNELS-1:0] w_snk_last, w_snk_vld, w_snk_rdy;

    for (genvar h = 0; h <= NODES; h++) begin : g_hop
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            if (h == 0) begin : g_src_host
                assign w_src_flit[h][c] = host_out_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
                assign w_src_last[h][c] = host_out_last[c];
                assign w_src_vld[h][c]  = host_out_valid[c];
                assign host_out_ready[c] = w_src_rdy[h][c];
            end else begin : g_src_tile
                localparam int T = (h - 1) * CHANNELS + c;
                assign w_src_flit[h][c] = tile_out_flit[T*FLIT_WIDTH +: FLIT_WIDTH];
                assign w_src_last[h][c] = tile_out_last[T];
                assign w_src_vld[h][c]  = tile_out_valid[T];
                assign tile_out_ready[T] = w_src_rdy[h][c];
            end

            if (h < NODES) begin : g_snk_tile
                localparam int T = h * CHANNELS + c;
                assign tile_in_flit[T*FLIT_WIDTH +: FLIT_WIDTH] = w_snk_flit[h][c];
                assign tile_in_last[T]  = w_snk_last[h][c];
                assign tile_in_valid[T] = w_snk_vld[h][c];
                assign w_snk_rdy[h][c]  = tile_in_ready[T];
            end else begin : g_snk_host
                assign host_in_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = w_snk_flit[h][c];
                assign host_in_last[c]  = w_snk_last[h][c];
                assign host_in_valid[c] = w_snk_vld[h][c];
                assign w_snk_rdy[h][c]  = host_in_ready[c];
            end

            debug_ring_fifo #(.FLIT_WIDTH(FLIT_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_fifo (
                .clk(clk), .rst(rst),
                .i_flit(w_src_flit[h][c]), .i_last(w_src_last[h][c]),
                .i_valid(w_src_vld[h][c]), .o_ready(w_src_rdy[h][c]),
                .o_flit(w_snk_flit[h][c]), .o_last(w_snk_last[h][c]),
                .o_valid(w_snk_vld[h][c]), .i_ready(w_snk_rdy[h][c])
            );

`ifdef DEBUG_RING_STATS_EN
            logic [31:0] r_flits, r_stalls;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_flits  <= '0;
                    r_stalls <= '0;
                end else begin
                    if (w_src_vld[h][c] && w_src_rdy[h][c] && r_flits != '1)
                        r_flits <= r_flits + 32'd1;
                    if (w_src_vld[h][c] && !w_src_rdy[h][c] && r_stalls != '1)
                        r_stalls <= r_stalls + 32'd1;
                end
            end
            assign stat_flits[(h*CHANNELS+c)*32 +: 32]  = r_flits;
            assign stat_stalls[(h*CHANNELS+c)*32 +: 32] = r_stalls;
`endif
        end
    end

`ifndef DEBUG_RING_STATS_EN
    assign stat_flits  = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_debug_ring_chain.sv
// Directed bench: three ring instances (depth 2 / 3 / 0) exercising latency, backpressure,
// full-FIFO push refusal, non-power-of-2 wrap, mid-packet reset and the wire-mode table.
module tb_debug_ring_chain;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT A: NODES=3, CHANNELS=2, DEPTH=2
    logic [31:0]  a_ho_flit, a_hi_flit;
    logic [1:0]   a_ho_last, a_ho_valid, a_ho_ready, a_hi_last, a_hi_valid, a_hi_ready;
    logic [95:0]  a_to_flit, a_ti_flit;
    logic [5:0]   a_to_last, a_to_valid, a_to_ready, a_ti_last, a_ti_valid, a_ti_ready;
    logic [255:0] a_sf, a_ss;

    // DUT B: NODES=1, CHANNELS=1, DEPTH=3 ; DUT C: same with DEPTH=0
    logic [15:0] b_ho_flit, b_hi_flit, b_to_flit, b_ti_flit;
    logic b_ho_last, b_ho_valid, b_ho_ready, b_hi_last, b_hi_valid, b_hi_ready;
    logic b_to_last, b_to_valid, b_to_ready, b_ti_last, b_ti_valid, b_ti_ready;
    logic [63:0] b_sf, b_ss;
    logic [15:0] c_ho_flit, c_hi_flit, c_to_flit, c_ti_flit;
    logic c_ho_last, c_ho_valid, c_ho_ready, c_hi_last, c_hi_valid, c_hi_ready;
    logic c_to_last, c_to_valid, c_to_ready, c_ti_last, c_ti_valid, c_ti_ready;
    logic [63:0] c_sf, c_ss;

    debug_ring_chain #(.NODES(3), .CHANNELS(2), .FLIT_WIDTH(16), .BUF_DEPTH(2)) u_a (
        .clk(clk), .rst(rst),
        .host_out_flit(a_ho_flit), .host_out_last(a_ho_last), .host_out_valid(a_ho_valid), .host_out_ready(a_ho_ready),
        .host_in_flit(a_hi_flit), .host_in_last(a_hi_last), .host_in_valid(a_hi_valid), .host_in_ready(a_hi_ready),
        .tile_out_flit(a_to_flit), .tile_out_last(a_to_last), .tile_out_valid(a_to_valid), .tile_out_ready(a_to_ready),
        .tile_in_flit(a_ti_flit), .tile_in_last(a_ti_last), .tile_in_valid(a_ti_valid), .tile_in_ready(a_ti_ready),
        .stat_flits(a_sf), .stat_stalls(a_ss));

    debug_ring_chain #(.NODES(1), .CHANNELS(1), .FLIT_WIDTH(16), .BUF_DEPTH(3)) u_b (
        .clk(clk), .rst(rst),
        .host_out_flit(b_ho_flit), .host_out_last(b_ho_last), .host_out_valid(b_ho_valid), .host_out_ready(b_ho_ready),
        .host_in_flit(b_hi_flit), .host_in_last(b_hi_last), .host_in_valid(b_hi_valid), .host_in_ready(b_hi_ready),
        .tile_out_flit(b_to_flit), .tile_out_last(b_to_last), .tile_out_valid(b_to_valid), .tile_out_ready(b_to_ready),
        .tile_in_flit(b_ti_flit), .tile_in_last(b_ti_last), .tile_in_valid(b_ti_valid), .tile_in_ready(b_ti_ready),
        .stat_flits(b_sf), .stat_stalls(b_ss));

    debug_ring_chain #(.NODES(1), .CHANNELS(1), .FLIT_WIDTH(16), .BUF_DEPTH(0)) u_c (
        .clk(clk), .rst(rst),
        .host_out_flit(c_ho_flit), .host_out_last(c_ho_last), .host_out_valid(c_ho_valid), .host_out_ready(c_ho_ready),
        .host_in_flit(c_hi_flit), .host_in_last(c_hi_last), .host_in_valid(c_hi_valid), .host_in_ready(c_hi_ready),
        .tile_out_flit(c_to_flit), .tile_out_last(c_to_last), .tile_out_valid(c_to_valid), .tile_out_ready(c_to_ready),
        .tile_in_flit(c_ti_flit), .tile_in_last(c_ti_last), .tile_in_valid(c_ti_valid), .tile_in_ready(c_ti_ready),
        .stat_flits(c_sf), .stat_stalls(c_ss));

    typedef struct {
        logic        v;
        logic [15:0] f;
        logic        l;
        logic        r;
        logic        ev;
        logic [15:0] ef;
        logic        el;
        logic        er;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd, budget;
        tv[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1};
        tv[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0};
        tv[2] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1};
        tv[3] = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b1};
        tv[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tv[5] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        tv[6] = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        tv[7] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1};
        tv[8] = '{1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b1};

        rst = 1'b1;
        a_ho_flit = '0; a_ho_last = '0; a_ho_valid = '0; a_hi_ready = '1;
        a_to_flit = '0; a_to_last = '0; a_to_valid = '0; a_ti_ready = '1;
        b_ho_flit = '0; b_ho_last = 1'b0; b_ho_valid = 1'b0; b_hi_ready = 1'b1;
        b_to_flit = '0; b_to_last = 1'b0; b_to_valid = 1'b0; b_ti_ready = 1'b1;
        c_ho_flit = '0; c_ho_last = 1'b0; c_ho_valid = 1'b0; c_hi_ready = 1'b1;
        c_to_flit = '0; c_to_last = 1'b0; c_to_valid = 1'b0; c_ti_ready = 1'b1;
        cyc(); cyc();

        chk("rst_host_ready", 64'(a_ho_ready), 64'h0);
        chk("rst_tile_ready", 64'(a_to_ready), 64'h0);
        chk("rst_tile_valid", 64'(a_ti_valid), 64'h0);
        chk("rst_host_valid", 64'(a_hi_valid), 64'h0);
        chk("rst_tile_flit",  64'(a_ti_flit[63:0]), 64'h0);
        chk("rst_b_ready",    64'(b_ho_ready), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_host_ready", 64'(a_ho_ready), 64'h3);
        chk("post_rst_tile_ready", 64'(a_to_ready), 64'h3f);

        // single flit, 1-cycle latency, ch1 untouched
        a_ho_valid = 2'b01; a_ho_flit = 32'h0000_1234; a_ho_last = 2'b01;
        #1;
        chk("t1_ready", 64'(a_ho_ready[0]), 64'h1);
        chk("t1_no_fallthrough", 64'(a_ti_valid), 64'h0);
        cyc();
        a_ho_valid = '0; a_ho_last = '0;
        chk("t1_valid", 64'(a_ti_valid), 64'h01);
        chk("t1_flit", 64'(a_ti_flit[15:0]), 64'h1234);
        chk("t1_last", 64'(a_ti_last[0]), 64'h1);
        chk("t1_ch1_flit", 64'(a_ti_flit[31:16]), 64'h0);
        cyc();
        chk("t1_drained", 64'(a_ti_valid), 64'h0);

        // backpressure to full, then pop+push in same cycle
        a_ti_ready = 6'b111110;
        for (int k = 0; k < 2; k++) begin
            a_ho_valid = 2'b01; a_ho_flit = {16'h0, 16'hA000 + 16'(k)};
            #1;
            chk("t2_accept", 64'(a_ho_ready[0]), 64'h1);
            cyc();
        end
        a_ho_flit = {16'h0, 16'hA002};
        chk("t2_full", 64'(a_ho_ready[0]), 64'h0);
        chk("t2_head", 64'(a_ti_flit[15:0]), 64'hA000);
        a_ti_ready[0] = 1'b1;
        cyc();
        a_ti_ready[0] = 1'b0;
        chk("t3_refused_count1", 64'(a_ho_ready[0]), 64'h1);
        chk("t3_head_a1", 64'(a_ti_flit[15:0]), 64'hA001);
        cyc();
        a_ho_valid = '0; a_ti_ready[0] = 1'b1;
        chk("t3_full_again", 64'(a_ho_ready[0]), 64'h0);
        chk("t3_head_still_a1", 64'(a_ti_flit[15:0]), 64'hA001);
        cyc();
        chk("t2_a2_valid", 64'(a_ti_valid[0]), 64'h1);
        chk("t2_a2", 64'(a_ti_flit[15:0]), 64'hA002);
        cyc();
        chk("t2_empty", 64'(a_ti_valid), 64'h0);

        // mid-packet reset on ch1
        a_ti_ready = 6'b111101;
        for (int k = 0; k < 2; k++) begin
            a_ho_valid = 2'b10; a_ho_flit = {16'hB000 + 16'(k), 16'h0}; a_ho_last = 2'b00;
            #1;
            chk("t5_accept", 64'(a_ho_ready[1]), 64'h1);
            cyc();
        end
        chk("t5_pending", 64'(a_ti_valid), 64'h02);
        rst = 1'b1; a_ho_valid = '0;
        #1;
        chk("t5_rst_ready", 64'(a_ho_ready), 64'h0);
        chk("t5_rst_valid", 64'(a_ti_valid), 64'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_flushed", 64'(a_ti_valid), 64'h0);
        chk("t5_ready_back", 64'(a_ho_ready), 64'h3);
        cyc();
        chk("t5_stay_empty", 64'(a_ti_valid), 64'h0);
        chk("t5_host_in_empty", 64'(a_hi_valid), 64'h0);
        a_ti_ready = '1;

        // depth 3 stream with random sink ready
        sent = 0; rcvd = 0; budget = 0;
        while (rcvd < 10 && budget < 400) begin
            b_ho_valid = (sent < 10);
            b_ho_flit  = 16'(sent);
            b_ti_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_ti_valid && b_ti_ready) begin
                chk("t4_order", 64'(b_ti_flit), 64'(rcvd));
                rcvd++;
            end
            if (b_ho_valid && b_ho_ready) sent++;
            cyc();
            budget++;
        end
        b_ho_valid = 1'b0;
        chk("t4_all_received", 64'(rcvd), 64'd10);

        // depth 0 wire-mode table
        for (int i = 0; i < 9; i++) begin
            c_ho_valid = tv[i].v; c_ho_flit = tv[i].f; c_ho_last = tv[i].l; c_ti_ready = tv[i].r;
            #1;
            chk("t6_valid", 64'(c_ti_valid), 64'(tv[i].ev));
            chk("t6_flit",  64'(c_ti_flit),  64'(tv[i].ef));
            chk("t6_last",  64'(c_ti_last),  64'(tv[i].el));
            chk("t6_ready", 64'(c_ho_ready), 64'(tv[i].er));
            cyc();
        end
        c_ho_valid = 1'b0;
`ifdef DEBUG_RING_STATS_EN
        chk("t6_stat_flits",  64'(c_sf[31:0]), 64'd5);
        chk("t6_stat_stalls", 64'(c_ss[31:0]), 64'd3);
`else
        chk("t6_stat_flits",  64'(c_sf[31:0]), 64'd0);
        chk("t6_stat_stalls", 64'(c_ss[31:0]), 64'd0);
`endif
        chk("t6_stat_hop1", 64'(c_sf[63:32]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
